cut_controller: RTL and testbench

CUT_CONTROLLER -- requirements
Module: cut_controller

---
 rtl/cut_controller.sv | 134 +++++++++++++
 tb/tb_cut_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_controller.sv
// cut_controller: runs a job of N cuts.
// Each cut is a feed gap followed by a cut request held until the downstream
// driver reports completion, with a watchdog for a driver that never answers.
module cut_controller #(
   parameter int FEED_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] num_cuts_i,
   input  logic       abort_i,
   input  logic       cut_end_i,
   output logic       cut_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [7:0] cuts_done_o
);

   localparam int FEED_W    = $clog2(FEED_CYCLES + 1);
   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FEED_W-1:0]    FEED_LAST    = FEED_W'(FEED_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      CUT,
      DONE
   } state_t;

   state_t               state;
   logic [7:0]           target;
   logic [FEED_W-1:0]    feed_cnt;
   logic [TIMEOUT_W-1:0] timeout_cnt;
   logic                 cut_end_q;
   logic                 cut_end_rise;
   logic [7:0]           cuts_next;

   assign cut_end_rise = cut_end_i & ~cut_end_q;
   assign cuts_next    = cuts_done_o + 8'd1;

   // Previous-cycle copy of cut_end_i, tracked in every state so a level that is already high on CUT entry is not mistaken for a completion edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cut_end_q <= 1'b0;
      end else begin
         cut_end_q <= cut_end_i;
      end
   end

   // Job sequencer: abort outranks a completion edge, which outranks the watchdog expiring in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         target      <= 8'd0;
         feed_cnt    <= '0;
         timeout_cnt <= '0;
         cut_o       <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         cuts_done_o <= 8'd0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  target      <= num_cuts_i;
                  cuts_done_o <= 8'd0;
                  err_o       <= 1'b0;
                  busy_o      <= 1'b1;
                  feed_cnt    <= '0;
                  if (num_cuts_i == 8'd0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= FEED;
                  end
               end
            end
            FEED: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  cut_o  <= 1'b0;
               end else if (feed_cnt == FEED_LAST) begin
                  state       <= CUT;
                  cut_o       <= 1'b1;
                  timeout_cnt <= '0;
               end else begin
                  feed_cnt <= feed_cnt + 1'b1;
               end
            end
            CUT: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  cut_o  <= 1'b0;
               end else if (cut_end_rise) begin
                  cut_o       <= 1'b0;
                  cuts_done_o <= cuts_next;
                  feed_cnt    <= '0;
                  if (cuts_next == target) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= FEED;
                  end
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  cut_o  <= 1'b0;
                  err_o  <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               cut_o  <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               cut_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cut_controller.sv
// tb_cut_controller: randomized jobs against an event-timeline reference model.
// Each job's input waveform is planned up front; the model derives from it the
// cycle of every visible output change and queues them for the monitor.
module tb_cut_controller;

   localparam int FEED   = 4;
   localparam int TO     = 50;
   localparam int MAXLEN = 1024;

   typedef enum int {EV_BUSY, EV_RISE, EV_FALL, EV_DONE, EV_ERR, EV_IDLE} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       cyc;
      int       cuts;
      bit       err;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] num_cuts_i = 8'd0;
   logic       abort_i = 1'b0;
   logic       cut_end_i = 1'b0;
   logic       cut_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [7:0] cuts_done_o;

   int  cyc = 0;
   int  compared = 0;
   int  mismatched = 0;
   int  cuts_m = 0;
   int  err_m = 0;
   bit  mon_en = 1'b0;
   ev_t exp_q[$];
   logic cut_q = 1'b0;
   logic busy_q = 1'b0;
   logic err_q = 1'b0;

   bit         start_a [MAXLEN];
   logic [7:0] ncuts_a [MAXLEN];
   bit         abort_a [MAXLEN];
   bit         cend_a  [MAXLEN];
   bit         rst_a   [MAXLEN];

   cut_controller #(
      .FEED_CYCLES   (FEED),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .num_cuts_i (num_cuts_i),
      .abort_i    (abort_i),
      .cut_o      (cut_o),
      .cut_end_i  (cut_end_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .cuts_done_o(cuts_done_o)
   );

   // Free-running clock and a count of rising edges used to timestamp events
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input ev_kind_e kind, input int c, input int cuts, input bit err);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.cuts = cuts;
      e.err  = err;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic observe(input ev_kind_e kind);
      ev_t e;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL event: got %s at cycle %0d cuts=%0d err=%0b, expected no event",
                  kind.name(), cyc, cuts_done_o, err_o);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || cuts_done_o !== 8'(e.cuts) || err_o !== e.err) begin
            mismatched++;
            $display("[TB] FAIL event: got %s cyc=%0d cuts=%0d err=%0b, expected %s cyc=%0d cuts=%0d err=%0b",
                     kind.name(), cyc, cuts_done_o, err_o, e.kind.name(), e.cyc, e.cuts, e.err);
         end
      end
   endtask

   // Monitor: turn output changes into events and check them against the queue
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy_o && !busy_q) observe(EV_BUSY);
         if (cut_o && !cut_q)   observe(EV_RISE);
         if (!cut_o && cut_q)   observe(EV_FALL);
         if (done_o)            observe(EV_DONE);
         if (err_o && !err_q)   observe(EV_ERR);
         if (!busy_o && busy_q) observe(EV_IDLE);
      end
      cut_q  <= cut_o;
      busy_q <= busy_o;
      err_q  <= err_o;
   end

   // One job: plan inputs, derive the expected event timeline, then drive it.
   // fixed_d: cut_end delay after each cut_o rise (0 = random, >TO = never).
   // kill_kind: 0 none, 1 abort, 2 reset; applied in cut kill_k, in FEED or CUT.
   task automatic applyStimulus(input bit no_gap, input int n, input int fixed_d,
                                input int kill_kind, input int kill_k, input bit kill_in_cut,
                                input int kill_dk, input bit preheld);
      ev_t loc[$];
      ev_t ev;
      int  t, e, c_cut, p_edge, lim, d, h, x, a, i, c_after, len, base;
      bit  fin;
      for (int j = 0; j < MAXLEN; j++) begin
         start_a[j] = 1'b0;
         ncuts_a[j] = 8'($urandom);
         abort_a[j] = 1'b0;
         cend_a[j]  = 1'b0;
         rst_a[j]   = 1'b0;
      end
      start_a[0] = 1'b1;
      ncuts_a[0] = 8'(n);
      abort_a[0] = 1'($urandom_range(0, 1));
      loc.push_back(mk(EV_BUSY, 0, 0, 1'b0));
      e = 1;
      if (n == 0) begin
         loc.push_back(mk(EV_DONE, 0, 0, 1'b0));
         loc.push_back(mk(EV_IDLE, 1, 0, 1'b0));
         cuts_m = 0;
         err_m  = 0;
      end else begin
         t   = 0;
         i   = 0;
         fin = 1'b0;
         while (!fin) begin
            c_after = (kill_kind == 2) ? 0 : i;
            if (kill_kind != 0 && kill_k == i && !kill_in_cut) begin
               a = t + ((kill_dk == 0) ? int'($urandom_range(1, FEED)) : kill_dk);
               abort_a[a] = (kill_kind == 1);
               rst_a[a]   = (kill_kind == 2);
               loc.push_back(mk(EV_IDLE, a, c_after, 1'b0));
               e = a; cuts_m = c_after; err_m = 0; fin = 1'b1;
            end else begin
               c_cut = t + FEED;
               loc.push_back(mk(EV_RISE, c_cut, i, 1'b0));
               if (fixed_d != 0) d = fixed_d;
               else if ($urandom_range(0, 1) == 1) d = 10;
               else d = int'($urandom_range(1, TO + 6));
               if (preheld) begin
                  x = int'($urandom_range(0, 5));
                  for (int p = c_cut - 2; p <= c_cut + x; p++) cend_a[p] = 1'b1;
                  if (d < x + 2) d = x + 2;
               end
               if (d <= TO) begin
                  h = int'($urandom_range(1, 3));
                  for (int p = c_cut + d; p < c_cut + d + h; p++) cend_a[p] = 1'b1;
               end
               p_edge = -1;
               for (int p = c_cut + 1; p <= c_cut + TO; p++)
                  if (p_edge < 0 && cend_a[p] && !cend_a[p-1]) p_edge = p;
               lim = (p_edge < 0) ? c_cut + TO : p_edge;
               if (kill_kind != 0 && kill_k == i && kill_in_cut) begin
                  if (kill_dk == 0) a = c_cut + int'($urandom_range(1, lim - c_cut));
                  else a = c_cut + ((kill_dk > lim - c_cut) ? lim - c_cut : kill_dk);
                  abort_a[a] = (kill_kind == 1);
                  rst_a[a]   = (kill_kind == 2);
                  loc.push_back(mk(EV_FALL, a, c_after, 1'b0));
                  loc.push_back(mk(EV_IDLE, a, c_after, 1'b0));
                  e = a; cuts_m = c_after; err_m = 0; fin = 1'b1;
               end else if (p_edge >= 0) begin
                  loc.push_back(mk(EV_FALL, p_edge, i + 1, 1'b0));
                  if (i + 1 == n) begin
                     loc.push_back(mk(EV_DONE, p_edge, n, 1'b0));
                     loc.push_back(mk(EV_IDLE, p_edge + 1, n, 1'b0));
                     if ($urandom_range(0, 3) == 0) abort_a[p_edge + 1] = 1'b1;
                     e = p_edge + 1; cuts_m = n; err_m = 0; fin = 1'b1;
                  end else begin
                     t = p_edge;
                  end
               end else begin
                  loc.push_back(mk(EV_FALL, c_cut + TO, i, 1'b1));
                  loc.push_back(mk(EV_ERR, c_cut + TO, i, 1'b1));
                  loc.push_back(mk(EV_IDLE, c_cut + TO, i, 1'b1));
                  e = c_cut + TO; cuts_m = i; err_m = 1; fin = 1'b1;
               end
               i++;
            end
         end
      end
      for (int j = 1; j <= e; j++) start_a[j] = ($urandom_range(0, 4) == 0);
      len = e + 3;
      for (int p = 0; p < MAXLEN; p++) if (cend_a[p] && p + 3 > len) len = p + 3;
      if (!no_gap) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            start_i    = 1'b0;
            abort_i    = 1'($urandom_range(0, 1));
            cut_end_i  = 1'b0;
            num_cuts_i = 8'($urandom);
            rst        = 1'b0;
         end
      end
      @(negedge clk);
      base = cyc + 1;
      foreach (loc[k]) begin
         ev = loc[k];
         ev.cyc = ev.cyc + base;
         exp_q.push_back(ev);
      end
      for (int j = 0; j < len; j++) begin
         if (j > 0) @(negedge clk);
         start_i    = start_a[j];
         num_cuts_i = ncuts_a[j];
         abort_i    = abort_a[j];
         cut_end_i  = cend_a[j];
         rst        = rst_a[j];
      end
      @(negedge clk);
      start_i   = 1'b0;
      abort_i   = 1'b0;
      cut_end_i = 1'b0;
      rst       = 1'b0;
      checkOutput("idle_cuts_done", 32'(cuts_done_o), 32'(cuts_m));
      checkOutput("idle_err", 32'(err_o), 32'(err_m));
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
      checkOutput("idle_cut", 32'(cut_o), 32'd0);
      checkOutput("pending_events", 32'(exp_q.size()), 32'd0);
   endtask

   // Directed jobs for the named behaviours, then a randomized batch
   initial begin
      int n, kk;
      repeat (3) @(negedge clk);
      checkOutput("reset_cut", 32'(cut_o), 32'd0);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_done", 32'(done_o), 32'd0);
      checkOutput("reset_err", 32'(err_o), 32'd0);
      checkOutput("reset_cuts_done", 32'(cuts_done_o), 32'd0);
      mon_en = 1'b1;
      $display("[TB] directed jobs");
      applyStimulus(1'b1, 3, 10, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 2, 99, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 5, 10, 1, 1, 1'b1, 0, 1'b0);
      applyStimulus(1'b0, 5, 10, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 2, 10, 0, 0, 1'b0, 0, 1'b1);
      applyStimulus(1'b0, 3, 10, 2, 1, 1'b0, 2, 1'b0);
      applyStimulus(1'b0, 1, TO, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1, TO - 1, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1, TO + 1, 0, 0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 2, 10, 1, 0, 1'b0, FEED, 1'b0);
      applyStimulus(1'b0, 2, 20, 1, 0, 1'b1, 20, 1'b0);
      applyStimulus(1'b0, 1, 99, 1, 0, 1'b1, TO, 1'b0);
      applyStimulus(1'b0, 2, 10, 2, 0, 1'b1, 0, 1'b0);
      $display("[TB] random jobs");
      for (int r = 0; r < 30; r++) begin
         n  = int'($urandom_range(0, 6));
         kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         applyStimulus(1'b0, n, 0, kk, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0,
                       ($urandom_range(0, 3) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Watchdog so a stuck run still ends with a report
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
